// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit channel.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BAUD_W    = 16;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte FIFO: CPU write side, serializer read side, combinational read data.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic [ADDR_WIDTH:0]  count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d;
  logic [PTR_W-1:0]     rd_q, rd_d;
  logic                 push_ok_c;
  logic                 pop_ok_c;

  // Occupancy flags and next pointers; a push while full is dropped even alongside a pop.
  always_comb begin
    count     = wr_q - rd_q;
    empty     = (wr_q == rd_q);
    full      = (count == PTR_W'(DEPTH));
    push_ok_c = push && !full;
    pop_ok_c  = pop && !empty;
    wr_d      = wr_q + PTR_W'(push_ok_c);
    rd_d      = rd_q + PTR_W'(pop_ok_c);
    rdata     = mem_q[rd_q[ADDR_WIDTH-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_q[ADDR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_chan.sv
// UART transmit channel: TX FIFO plus 8-bit LSB-first serializer.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_chan
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_write,
  input  logic [7:0]           cpu_data,
  input  logic [15:0]          baud_div,
  input  logic                 tx_enable,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic [ADDR_WIDTH:0]  tx_count
);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]      baud_lat_q, baud_lat_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   pop_c;
  logic                   bit_end_c;
  logic [DATA_BITS-1:0]   fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  tx_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu_write),
    .wdata (cpu_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Serializer next state; txd/busy are derived from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_lat_d = baud_lat_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    pop_c      = 1'b0;
    bit_end_c  = (baud_cnt_q == baud_lat_q);
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_enable && !tx_empty) begin
          pop_c      = 1'b1;
          shift_d    = fifo_rdata;
          baud_lat_d = baud_div;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^fifo_rdata;
`endif
          state_d    = START;
        end
      end
      START: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end_c) state_d = DATA;
      end
      DATA: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end_c) state_d = STOP;
      end
`endif
      STOP: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Serializer registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      baud_lat_q <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_lat_q <= baud_lat_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;

endmodule

// File: doc/uart_tx_chan.md
UART_TX_CHAN -- requirements
Module: uart_tx_chan

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving TX FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), giving FIFO address width.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_write  input  1  push cpu_data into TX FIFO.
REQ-006 SHALL have port cpu_data  input  8  byte to transmit.
REQ-007 SHALL have port baud_div  input  16  bit period minus one, in clk cycles.
REQ-008 SHALL have port tx_enable  input  1  permit starting new frames.
REQ-009 SHALL have port txd  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  frame in progress.
REQ-011 SHALL have port tx_full  output  1  FIFO holds DEPTH bytes.
REQ-012 SHALL have port tx_empty  output  1  FIFO holds zero bytes.
REQ-013 SHALL have port tx_count  output  ADDR_WIDTH+1  FIFO occupancy.

Function
REQ-014 SHALL accept a push only when cpu_write=1 and tx_full=0 in that cycle; a push while full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-015 SHALL use ADDR_WIDTH+1-bit read/write pointers, wrapping modulo 2*DEPTH; tx_count = wr-rd, tx_empty = (wr==rd), tx_full = (tx_count==DEPTH).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with tx_enable=1 and tx_empty=0, SHALL pop one byte into the shift register, latch baud_div, and enter START next cycle.
REQ-018 SHALL drive txd low in START, data bits LSB-first in DATA, parity in PARITY, high in STOP and IDLE.
REQ-019 Each of START, each DATA bit, PARITY and STOP SHALL last exactly latched baud_div+1 clk cycles; baud_div=0 gives a 1-cycle bit.
REQ-020 baud_div changes mid-frame SHALL NOT affect the current frame.
REQ-021 DATA SHALL count 8 bits with a 3-bit index, then go to PARITY (if compiled in) else STOP.
REQ-022 After STOP, SHALL return to IDLE; if enabled and not empty, the next pop SHALL occur in that IDLE cycle, giving one idle-high cycle between frames.
REQ-023 tx_enable deassert mid-frame SHALL let the current frame complete and inhibit further pops.
REQ-024 tx_busy SHALL be 1 in every state except IDLE.
REQ-025 First txd low SHALL appear 1 cycle after the pop cycle; a push into an empty FIFO pops at earliest 1 cycle after the push.

Reset
REQ-026 On rst_n low, SHALL asynchronously set FSM=IDLE, pointers=0, bit/baud counters=0, txd=1, tx_busy=0, tx_empty=1, tx_full=0, tx_count=0.
REQ-027 Reset mid-frame SHALL abort the frame, drive txd high immediately, and discard FIFO contents; FIFO memory need not be reset.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state present, txd in PARITY = even parity (XOR of 8 data bits); frame = 11 bits.
REQ-029 UART_TX_PARITY_EN undefined: no PARITY state or logic, DATA goes directly to STOP; frame = 10 bits.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum tx_state_t and constant DATA_BITS=8.
REQ-031 SHALL instantiate one sub-module tx_fifo (CPU write side, serializer read side, combinational read data) plus the serializer FSM in uart_tx_chan.

Verification
REQ-032 Push 0xA5, baud_div=3, enable: txd = 0,1,0,1,0,0,1,0,1,[parity 0],1, each held 4 clks; tx_busy high for 40/44 clks.
REQ-033 Push 17 bytes with tx_enable=0, DEPTH=16: tx_full=1, tx_count=16, 17th byte never transmitted.
REQ-034 Push 0x00 and 0xFF back-to-back, baud_div=0: two frames separated by exactly one idle-high cycle; parity 0 then 0.
REQ-035 Deassert tx_enable during bit 3 of a frame with 2 bytes queued: frame completes, tx_count stays 1, txd idle high.
REQ-036 Assert rst_n low during DATA: txd=1, tx_busy=0, tx_empty=1 immediately; after release, idle until a new push.
REQ-037 Change baud_div 3->7 mid-frame: current frame keeps 4-clk bits, next frame uses 8-clk bits.
